// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the four-bank interleaved memory.
//   NUM_BANKS    number of interleaved banks
//   BUSY_CYCLES  cycles a bank is occupied per accepted access (incl. accept cycle)
//   READ_LATENCY cycles from read acceptance to data_out valid
//   BANK_LSB/MSB, ROW_LSB  address field positions within the byte address
package mem_pkg;
  localparam int NUM_BANKS    = 4;
  localparam int BUSY_CYCLES  = 4;
  localparam int READ_LATENCY = 2;
  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int BANK_LSB     = 1;
  localparam int BANK_MSB     = 2;
  localparam int ROW_LSB      = 3;
  localparam int CNT_W        = $clog2(BUSY_CYCLES);

  typedef logic [BANK_MSB-BANK_LSB:0] bank_sel_t;
  typedef logic [CNT_W-1:0]           busy_cnt_t;

  function automatic bank_sel_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_MSB:BANK_LSB];
  endfunction
endpackage

// File: rtl/four_bank_mem_if.sv
// four_bank_mem_if: request/response bundle between the cache controller
// (master) and the interleaved memory (slave).
//   addr, data_in, wr, rd : request from master
//   data_out, stall, busy, err : response from memory
interface four_bank_mem_if;
  import mem_pkg::*;

  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data_in;
  logic                 wr;
  logic                 rd;
  logic [DATA_W-1:0]    data_out;
  logic                 stall;
  logic [NUM_BANKS-1:0] busy;
  logic                 err;

  modport master (output addr, data_in, wr, rd,
                  input  data_out, stall, busy, err);
  modport slave  (input  addr, data_in, wr, rd,
                  output data_out, stall, busy, err);
endinterface

// File: rtl/mem_bank.sv
// mem_bank: one bank of the interleaved memory.
//   clk, rst   clock, async active-low reset (busy counter only; array kept)
//   en         access accepted for this bank this cycle
//   wr         1 = write, 0 = read (only meaningful with en)
//   row        row index within the bank
//   data_in    write data
//   data_out   row contents sampled at the last accepted read
//   busy       bank occupied by a recent access
module mem_bank
  import mem_pkg::*;
#(
  parameter int ROW_BITS = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr,
  input  logic [ROW_BITS-1:0] row,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                busy
);

  logic [DATA_W-1:0] mem [2**ROW_BITS];
  busy_cnt_t         cnt;

  // Array and read sample carry no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) mem[row] <= data_in;
      else    data_out <= mem[row];
    end
  end

  // Accept cycle plus BUSY_CYCLES-1 counted cycles form the busy window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (en)            cnt <= busy_cnt_t'(BUSY_CYCLES - 1);
    else if (cnt != '0)     cnt <= cnt - busy_cnt_t'(1);
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/four_bank_mem.sv
// four_bank_mem: word-addressed, 4-way interleaved main memory with a fixed
// 2-cycle read latency, per-bank busy windows, stall and error reporting.
//   clk   system clock
//   rst   async active-low reset
//   bus   slave side of four_bank_mem_if (request in, data/stall/busy/err out)
module four_bank_mem
  import mem_pkg::*;
#(
  parameter int ROW_BITS = 13
) (
  input  logic            clk,
  input  logic            rst,
  four_bank_mem_if.slave  bus
);

  logic                 req;
  logic                 illegal;
  logic                 legal;
  logic                 accept;
  bank_sel_t            sel;
  bank_sel_t            sel1;
  logic [NUM_BANKS-1:0] busy_vec;
  logic [NUM_BANKS-1:0] en;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic [ROW_BITS-1:0]  row;
  logic                 v1;
  logic                 v2;
  logic [DATA_W-1:0]    dq;

  assign row = bus.addr[ROW_LSB +: ROW_BITS];

  // Nothing is accepted or flagged while reset is held.
  always_comb begin
    req     = bus.rd | bus.wr;
    illegal = (bus.rd & bus.wr) | (req & bus.addr[0]);
    sel     = bank_of(bus.addr);
    legal   = rst & req & ~illegal;
    accept  = legal & ~busy_vec[sel];
    en      = '0;
    en[sel] = accept;
  end

  assign bus.err   = rst & illegal;
  assign bus.stall = legal & busy_vec[sel];
  assign bus.busy  = busy_vec;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    mem_bank #(.ROW_BITS(ROW_BITS)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .wr       (bus.wr),
      .row      (row),
      .data_in  (bus.data_in),
      .data_out (bank_rdata[i]),
      .busy     (busy_vec[i])
    );
  end

  // Stage 1 is the bank's own read sample; v1/sel1 track which bank holds it.
  // The busy window keeps a bank's sample stable until stage 2 takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      sel1 <= '0;
    end else begin
      v1   <= accept & bus.rd;
      sel1 <= sel;
      v2   <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (v1) dq <= bank_rdata[sel1];
  end

  assign bus.data_out = v2 ? dq : '0;

endmodule
